dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

Store buffer between the core's load/store path and data memory `dm`. Stores are queued in a small FIFO and written into `dm` one per cycle whenever the memory port is not needed by a load. Loads are checked against pending stores. On a matching address the load either stalls until the conflicting stores have drained, or, with forwarding compiled in, takes the data directly from the buffer. Store order into `dm` always equals program order.

## Interface
- `DEPTH`, 4: number of entries; a power of two, minimum 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `st_valid`  in  1  core presents a store this cycle.
- `st_ready`  out  1  buffer can accept a store; equals `!full`.
- `st_addr`  in  32  byte address of the store; only bits [8:2] are stored.
- `st_type`  in  3  DMType code from the shared encode definitions (`dm_word`, `dm_halfword`, `dm_byte`, ...).
- `st_data`  in  32  store data.
- `ld_valid`  in  1  core is performing a load this cycle.
- `ld_addr`  in  32  load byte address; bits [8:2] are compared.
- `ld_type`  in  3  DMType code of the load.
- `ld_stall`  out  1  the core must hold the load and retry next cycle.
- `ld_fwd`  out  1  load is served from the buffer; `ld_fwd_data` is valid.
- `ld_fwd_data`  out  32  forwarded load result, already extended.
- `mem_wr`  out  1  drives `dm` DMWr.
- `mem_addr`  out  7  drives `dm` addr[8:2].
- `mem_type`  out  3  drives `dm` DMType during a drain.
- `mem_din`  out  32  drives `dm` din.
- `sb_empty`  out  1  no pending stores; used for fence and halt.

## Operation
- Storage is a circular FIFO of {addr[8:2], type, data}, with `wr_ptr`, `rd_ptr`, and a `count` of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- `full = (count == DEPTH)`. `sb_empty = (count == 0)`.
- **Enqueue:** `st_valid && st_ready` writes the entry at `wr_ptr`, then increments `wr_ptr`.
  - `st_valid` while full: no write and no state change. The core must hold the store.
- **Load address match:** a match means any valid entry has addr[8:2] equal to `ld_addr[8:2]`. A store enqueued in the same cycle is not part of the compare.
- **Port busy:** the port is busy when `ld_valid && !ld_stall && !ld_fwd`, meaning the load is reading `dm` this cycle.
- **Drain:** when the buffer is non-empty and the port is not busy:
  - `mem_wr = 1`, and `mem_addr`, `mem_type`, `mem_din` come from the head entry.
  - The entry is popped at the clock edge.
  - Otherwise `mem_wr = 0`, and the other `mem_*` outputs hold the head fields (don't-care).
- **Push and pop in the same cycle:** `count` is unchanged and both pointers advance. When full, `st_ready` stays 0 in that cycle even if a pop occurs.
- **Without forwarding:** any match gives `ld_stall = 1` and `ld_fwd = 0`. The drain continues (the port is free), so the stall always resolves within `count` cycles.
- **Load hazard when empty:** none; `ld_stall = 0` and the load reads `dm` directly.

## Timing
- `st_ready`, `ld_stall`, `ld_fwd`, `ld_fwd_data` and `mem_*` are combinational from the current state and inputs. All state is registered.
- A store accepted at edge N drains no earlier than the cycle after N, so it is visible in `dm` after edge N+1 at the earliest.
- Values during and after reset: pointers 0, `count` 0, `sb_empty = 1`, `st_ready = 1`, `mem_wr = 0`, `ld_stall = 0`, `ld_fwd = 0`, `ld_fwd_data = 0`.
- Asserting `rst` mid-drain discards all pending entries immediately. A `dm` write in flight at that edge is not guaranteed.
- `dm` write semantics are unchanged:
  - byte store writes [7:0];
  - halfword store writes [15:0];
  - word (or any other code) writes all 32 bits.

## Configuration
- `STBUF_FWD_EN` defined: forwarding logic is present.
  - Forwarding applies when the youngest matching entry is a `dm_word` store: `ld_fwd = 1`, `ld_stall = 0`.
  - `ld_fwd_data` is that entry's data extended per `ld_type`, with the same rules as `dm`: byte or halfword taken from the low bits, signed or unsigned.
  - If the youngest match is not a word store, `ld_stall = 1`.
- `STBUF_FWD_EN` not defined: `ld_fwd` and `ld_fwd_data` are tied to 0, and every match stalls.

## Test plan
- **Reset, then a single store:** reset, then `st_valid` `sw` 0x12345678 at 0x40. Expect `mem_wr = 1`, `mem_addr = 0x10`, `mem_din = 0x12345678` the next cycle, then `sb_empty = 1`.
- **Fill to full:** 4 back-to-back stores while `ld_valid` is held with a non-matching address. Expect `st_ready = 0` after the 4th and the 5th store held. Release the load: drains occur in order over 4 cycles, and `st_ready` returns to 1 after the first pop.
- **Hazard stall without `STBUF_FWD_EN`:**
  - Queue `sw` 0xAABBCCDD at 0x20, then load `lw` at 0x20. Expect `ld_stall = 1` for 1 cycle while the drain happens, then `ld_stall = 0`.
  - `dm` then returns 0xAABBCCDD.
- **Forwarding with `STBUF_FWD_EN`:**
  - Queue `sw` 0x000000F0 at 0x8, then `lb` at 0x8. Expect `ld_fwd = 1` and `ld_fwd_data = 0xFFFFFFF0`.
  - `lbu` at 0x8 gives 0x000000F0.
  - Queue `sb` at 0x8 after the `sw`: the `lb` now stalls.
- **Wrap-around:** 10 stores interleaved with drains. `dm` contents and drain order match program order across the pointer wrap.
- **Reset mid-operation:** 3 pending stores, assert `rst` asynchronously. Expect `sb_empty = 1` and `mem_wr = 0` immediately, and no further drains.

Source files
------------

// File: rtl/dm_store_buffer.sv
// Store buffer between the core load/store path and data memory: queues stores, drains one per free port cycle.
// Latency: accepted store drains no earlier than the next cycle; all outputs combinational from state + inputs.
// Backpressure: st_ready_o = !full; matching loads stall (or forward from a word store when STBUF_FWD_EN is defined).
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic [31:0] st_addr_i,
    input  logic [2:0]  st_type_i,
    input  logic [31:0] st_data_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    input  logic [2:0]  ld_type_i,
    output logic        ld_stall_o,
    output logic        ld_fwd_o,
    output logic [31:0] ld_fwd_data_o,
    output logic        mem_wr_o,
    output logic [6:0]  mem_addr_o,
    output logic [2:0]  mem_type_o,
    output logic [31:0] mem_din_o,
    output logic        sb_empty_o
);

    // DMType codes, mirroring the shared encode definitions used by dm.
    localparam logic [2:0] DM_WORD       = 3'd0;
`ifdef STBUF_FWD_EN
    localparam logic [2:0] DM_HALFWORD   = 3'd1;
    localparam logic [2:0] DM_HALFWORD_U = 3'd2;
    localparam logic [2:0] DM_BYTE       = 3'd3;
    localparam logic [2:0] DM_BYTE_U     = 3'd4;
`endif

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Entry storage; contents are only meaningful for slots inside [rd_ptr, rd_ptr+count).
    logic [6:0]    addr_q [DEPTH];
    logic [2:0]    type_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          port_busy;
    logic          match_any;
    logic [AW-1:0] scan_idx;

`ifdef STBUF_FWD_EN
    logic [2:0]    young_type;
    logic [31:0]   young_data;
    logic          fwd_hit;
`else
    logic          unused_fwd_inputs;
    assign unused_fwd_inputs = ^ld_type_i;
`endif

    // Only word address bits [8:2] participate in storage and comparison.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{st_addr_i[31:9], st_addr_i[1:0], ld_addr_i[31:9], ld_addr_i[1:0]};

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign st_ready_o = !full;
    assign sb_empty_o = empty;

    // A store presented in the same cycle is not yet in the array, so it never matches here.
    assign push = st_valid_i && !full;

`ifdef STBUF_FWD_EN
    // Sign/zero extension of forwarded word data, same rules as dm reads.
    function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] t);
        logic [31:0] r;
        case (t)
            DM_BYTE:       r = {{24{d[7]}}, d[7:0]};
            DM_BYTE_U:     r = {24'b0, d[7:0]};
            DM_HALFWORD:   r = {{16{d[15]}}, d[15:0]};
            DM_HALFWORD_U: r = {16'b0, d[15:0]};
            default:       r = d;
        endcase
        return r;
    endfunction
`endif

    // Scan valid entries oldest to youngest; the last hit is the youngest matching store.
    always_comb begin
        match_any = 1'b0;
        scan_idx  = '0;
`ifdef STBUF_FWD_EN
        young_type = DM_WORD;
        young_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + AW'(k);
            if ((CW'(k) < count_q) && (addr_q[scan_idx] == ld_addr_i[8:2])) begin
                match_any = 1'b1;
`ifdef STBUF_FWD_EN
                young_type = type_q[scan_idx];
                young_data = data_q[scan_idx];
`endif
            end
        end
    end

    // Load hazard resolution: forward from a youngest word store, otherwise stall on any match.
    always_comb begin
        ld_stall_o    = 1'b0;
        ld_fwd_o      = 1'b0;
        ld_fwd_data_o = '0;
`ifdef STBUF_FWD_EN
        fwd_hit = ld_valid_i && match_any && (young_type == DM_WORD);
        if (fwd_hit) begin
            ld_fwd_o      = 1'b1;
            ld_fwd_data_o = extend_load(young_data, ld_type_i);
        end else if (ld_valid_i && match_any) begin
            ld_stall_o = 1'b1;
        end
`else
        if (ld_valid_i && match_any) begin
            ld_stall_o = 1'b1;
        end
`endif
    end

    // The dm port belongs to the load only when it actually reads memory this cycle.
    assign port_busy = ld_valid_i && !ld_stall_o && !ld_fwd_o;
    assign pop       = !empty && !port_busy;

    // Drain port: head entry is always presented, mem_wr_o qualifies it.
    always_comb begin
        mem_wr_o   = pop;
        mem_addr_o = addr_q[rd_ptr_q];
        mem_type_o = type_q[rd_ptr_q];
        mem_din_o  = data_q[rd_ptr_q];
    end

    // Pointer and occupancy next-state; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every pending entry immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload write; no reset needed because count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr_i[8:2];
            type_q[wr_ptr_q] <= st_type_i;
            data_q[wr_ptr_q] <= st_data_i;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: scoreboard of expected drains plus a dm model fed from the drain port.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Covers both builds; forwarding expectations follow STBUF_FWD_EN.
module tb_dm_store_buffer;

    localparam logic [2:0] LW  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LB  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
`ifdef STBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]  a;
        logic [2:0]  t;
        logic [31:0] d;
    } drain_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [2:0]  st_type;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_type;
    logic        ld_stall, ld_fwd;
    logic [31:0] ld_fwd_data;
    logic        mem_wr;
    logic [6:0]  mem_addr;
    logic [2:0]  mem_type;
    logic [31:0] mem_din;
    logic        sb_empty;

    int checks   = 0;
    int failures = 0;

    drain_t      sb_q[$];
    logic [31:0] dm_model [128];
    logic [31:0] exp_dm   [128];

    dm_store_buffer #(.DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .st_valid_i   (st_valid),
        .st_ready_o   (st_ready),
        .st_addr_i    (st_addr),
        .st_type_i    (st_type),
        .st_data_i    (st_data),
        .ld_valid_i   (ld_valid),
        .ld_addr_i    (ld_addr),
        .ld_type_i    (ld_type),
        .ld_stall_o   (ld_stall),
        .ld_fwd_o     (ld_fwd),
        .ld_fwd_data_o(ld_fwd_data),
        .mem_wr_o     (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_type_o   (mem_type),
        .mem_din_o    (mem_din),
        .sb_empty_o   (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] t, input logic [31:0] d);
        logic [31:0] r;
        case (t)
            3'd3, 3'd4: r = {old[31:8], d[7:0]};
            3'd1, 3'd2: r = {old[31:16], d[15:0]};
            default:    r = d;
        endcase
        return r;
    endfunction

    // Drain monitor: every dm write must be the oldest outstanding store, in program order.
    always @(negedge clk) begin
        drain_t e;
        if (!rst && mem_wr) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_drain", {31'b0, mem_wr}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("drain_addr", {25'b0, mem_addr}, {25'b0, e.a});
                chk("drain_type", {29'b0, mem_type}, {29'b0, e.t});
                chk("drain_data", mem_din, e.d);
            end
            dm_model[mem_addr] = merge(dm_model[mem_addr], mem_type, mem_din);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic try_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d, output bit acc);
        drain_t e;
        st_valid = 1'b1;
        st_addr  = a;
        st_type  = t;
        st_data  = d;
        @(negedge clk);
        acc = st_ready;
        if (acc) begin
            e.a = a[8:2];
            e.t = t;
            e.d = d;
            sb_q.push_back(e);
            exp_dm[a[8:2]] = merge(exp_dm[a[8:2]], t, d);
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic store_retry(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
        bit acc;
        int n;
        n = 0;
        do begin
            try_store(a, t, d, acc);
            if (!acc) ld_valid = 1'b0;
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("store_timeout", {31'b0, acc}, 32'd1);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!sb_empty && n < 50) begin
            cyc();
            n++;
        end
        chk(tag, {31'b0, sb_empty}, 32'd1);
    endtask

    initial begin
        bit acc;
        drain_t e;
        for (int i = 0; i < 128; i++) begin
            dm_model[i] = '0;
            exp_dm[i]   = '0;
        end
        rst = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_type = LW; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_type = LW;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
        chk("rst_mem_wr",   {31'b0, mem_wr},   32'd0);
        chk("rst_ld_stall", {31'b0, ld_stall}, 32'd0);
        chk("rst_ld_fwd",   {31'b0, ld_fwd},   32'd0);
        chk("rst_fwd_data", ld_fwd_data, 32'd0);
        rst = 1'b0;
        cyc();

        // Single store: not written in its accept cycle, drained the next
        st_valid = 1'b1; st_addr = 32'h40; st_type = LW; st_data = 32'h12345678;
        @(negedge clk);
        chk("single_ready", {31'b0, st_ready}, 32'd1);
        chk("single_same_cycle_no_wr", {31'b0, mem_wr}, 32'd0);
        e.a = 7'h10; e.t = LW; e.d = 32'h12345678;
        sb_q.push_back(e);
        exp_dm[7'h10] = 32'h12345678;
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("single_mem_wr",   {31'b0, mem_wr}, 32'd1);
        chk("single_mem_addr", {25'b0, mem_addr}, 32'h10);
        chk("single_mem_din",  mem_din, 32'h12345678);
        cyc();
        chk("single_empty_after", {31'b0, sb_empty}, 32'd1);
        chk("single_dm", dm_model[7'h10], 32'h12345678);

        // Fill to full behind a non-matching load holding the port
        ld_valid = 1'b1; ld_addr = 32'h100; ld_type = LW;
        for (int i = 0; i < 4; i++) begin
            try_store(32'(i * 4), LW, 32'h1000 + 32'(i), acc);
            chk("fill_accept", {31'b0, acc}, 32'd1);
        end
        chk("fill_not_ready", {31'b0, st_ready}, 32'd0);
        try_store(32'h10, LW, 32'h1004, acc);
        chk("fifth_held", {31'b0, acc}, 32'd0);
        st_valid = 1'b1; st_addr = 32'h10; st_type = LW; st_data = 32'h1004;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("full_pop_ready_low", {31'b0, st_ready}, 32'd0);
        chk("full_pop_mem_wr",    {31'b0, mem_wr}, 32'd1);
        cyc();
        @(negedge clk);
        chk("ready_after_pop", {31'b0, st_ready}, 32'd1);
        if (st_ready) begin
            e.a = 7'h04; e.t = LW; e.d = 32'h1004;
            sb_q.push_back(e);
            exp_dm[7'h04] = 32'h1004;
        end
        cyc();
        st_valid = 1'b0;
        wait_empty("fill_drain_timeout");
        chk("fill_scoreboard_empty", sb_q.size(), 32'd0);

        // Hazard on a pending word store
        store_retry(32'h20, LW, 32'hAABBCCDD);
        ld_valid = 1'b1; ld_addr = 32'h20; ld_type = LW;
        @(negedge clk);
        chk("haz_stall",    {31'b0, ld_stall}, {31'b0, !FWD});
        chk("haz_fwd",      {31'b0, ld_fwd},   {31'b0, FWD});
        chk("haz_fwd_data", ld_fwd_data, FWD ? 32'hAABBCCDD : 32'd0);
        chk("haz_drain",    {31'b0, mem_wr}, 32'd1);
        cyc();
        chk("haz_stall_clear", {31'b0, ld_stall}, 32'd0);
        chk("haz_fwd_clear",   {31'b0, ld_fwd}, 32'd0);
        ld_valid = 1'b0;
        chk("haz_dm", dm_model[7'h08], 32'hAABBCCDD);

        // Forwarding / stall with signed and unsigned byte loads
        ld_valid = 1'b1; ld_addr = 32'h100; ld_type = LW;
        store_retry(32'h30, LW, 32'h11);
        store_retry(32'h08, LW, 32'hF0);
        ld_addr = 32'h08; ld_type = LB;
        @(negedge clk);
        chk("lb_fwd",      {31'b0, ld_fwd},   {31'b0, FWD});
        chk("lb_stall",    {31'b0, ld_stall}, {31'b0, !FWD});
        chk("lb_fwd_data", ld_fwd_data, FWD ? 32'hFFFFFFF0 : 32'd0);
        chk("lb_drain",    {31'b0, mem_wr}, 32'd1);
        cyc();
        ld_type = LBU;
        @(negedge clk);
        chk("lbu_fwd",      {31'b0, ld_fwd},   {31'b0, FWD});
        chk("lbu_stall",    {31'b0, ld_stall}, {31'b0, !FWD});
        chk("lbu_fwd_data", ld_fwd_data, FWD ? 32'h000000F0 : 32'd0);
        cyc();
        chk("lbu_after_stall", {31'b0, ld_stall}, 32'd0);
        chk("lbu_after_fwd",   {31'b0, ld_fwd}, 32'd0);

        // Youngest match is a byte store: always stalls until both drain
        ld_addr = 32'h100; ld_type = LW;
        store_retry(32'h08, LW, 32'hF0);
        store_retry(32'h08, LB, 32'h55);
        ld_addr = 32'h08; ld_type = LB;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("sb_young_stall", {31'b0, ld_stall}, 32'd1);
            chk("sb_young_nofwd", {31'b0, ld_fwd}, 32'd0);
            chk("sb_young_drain", {31'b0, mem_wr}, 32'd1);
            cyc();
        end
        @(negedge clk);
        chk("sb_young_released", {31'b0, ld_stall}, 32'd0);
        cyc();
        ld_valid = 1'b0;
        chk("sb_young_dm", dm_model[7'h02], 32'h00000055);

        // Wrap-around: mixed widths, occupancy built up by a held load
        for (int i = 0; i < 10; i++) begin
            ld_valid = (i % 3 != 2);
            ld_addr  = 32'h1FC;
            ld_type  = LW;
            store_retry(32'h80 + 32'((i % 4) * 4), (i % 3 == 0) ? LW : ((i % 3 == 1) ? LH : LB),
                        32'hA0B0C000 + 32'(i * 32'h111));
        end
        ld_valid = 1'b0;
        wait_empty("wrap_drain_timeout");
        for (int a = 0; a < 4; a++) begin
            chk("wrap_dm", dm_model[7'h20 + 7'(a)], exp_dm[7'h20 + 7'(a)]);
        end
        chk("wrap_scoreboard_empty", sb_q.size(), 32'd0);

        // Asynchronous reset with pending stores
        ld_valid = 1'b1; ld_addr = 32'h1FC; ld_type = LW;
        store_retry(32'h44, LW, 32'h1);
        store_retry(32'h48, LW, 32'h2);
        store_retry(32'h4C, LW, 32'h3);
        chk("pre_rst_pending", {31'b0, sb_empty}, 32'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_empty",    {31'b0, sb_empty}, 32'd1);
        chk("mid_rst_mem_wr",   {31'b0, mem_wr}, 32'd0);
        chk("mid_rst_st_ready", {31'b0, st_ready}, 32'd1);
        sb_q.delete();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_mem_wr", {31'b0, mem_wr}, 32'd0);
            chk("post_rst_empty",  {31'b0, sb_empty}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
